// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, syncs, blanking and frame
// markers, all registered and aligned to the counter values they describe.
module vga_timing_gen #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0
) (
    input  logic        vclock_in,
    input  logic        reset_n_in,
    input  logic        pix_en_in,
    output logic [11:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        blank_out,
    output logic        frame_start_out,
    output logic [7:0]  frame_count_out
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 4096 || V_TOTAL > 2048) begin : g_bad_totals
        $error("vga_timing_gen: H_TOTAL or V_TOTAL exceeds counter width");
    end

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic        h_last;
    logic        v_last;
    logic [11:0] h_nxt;
    logic [10:0] v_nxt;
    logic        hs_nxt;
    logic        vs_nxt;
    logic        bl_nxt;

    // Decode the counter values about to be loaded so every registered
    // output lines up with the count shown on the same cycle.
    always_comb begin
        h_last = (hcount_out == H_LAST);
        v_last = (vcount_out == V_LAST);
        h_nxt  = h_last ? 12'd0 : hcount_out + 12'd1;
        v_nxt  = vcount_out;
        if (h_last) begin
            v_nxt = v_last ? 11'd0 : vcount_out + 11'd1;
        end
        hs_nxt = (h_nxt >= HS_START && h_nxt < HS_END) ? H_POL : ~H_POL;
        vs_nxt = (v_nxt >= VS_START && v_nxt < VS_END) ? V_POL : ~V_POL;
        bl_nxt = (h_nxt >= H_ACT) || (v_nxt >= V_ACT);
    end

    always_ff @(posedge vclock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            hcount_out      <= 12'd0;
            vcount_out      <= 11'd0;
            hsync_out       <= ~H_POL;
            vsync_out       <= ~V_POL;
            blank_out       <= 1'b0;
            frame_start_out <= 1'b0;
            frame_count_out <= 8'd0;
        end else begin
            frame_start_out <= 1'b0;
            if (pix_en_in) begin
                hcount_out <= h_nxt;
                vcount_out <= v_nxt;
                hsync_out  <= hs_nxt;
                vsync_out  <= vs_nxt;
                blank_out  <= bl_nxt;
                if (h_last && v_last) begin
                    frame_start_out <= 1'b1;
                    frame_count_out <= frame_count_out + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance for line timing, tiny
// instance for frame wrap, both checked against a linear-position model.
module tb_vga_timing_gen;

    localparam int AHA = 1024, AHF = 24, AHS = 136, AHB = 160;
    localparam int AVA = 768, AVF = 3, AVS = 6, AVB = 29;
    localparam int AHT = AHA + AHF + AHS + AHB;
    localparam int AVT = AVA + AVF + AVS + AVB;
    localparam int BHA = 4, BHF = 1, BHS = 1, BHB = 1;
    localparam int BVA = 2, BVF = 1, BVS = 1, BVB = 1;
    localparam int BHT = BHA + BHF + BHS + BHB;
    localparam int BVT = BVA + BVF + BVS + BVB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, en_a, en_b;
    logic [11:0] a_h, b_h;
    logic [10:0] a_v, b_v;
    logic a_hs, a_vs, a_bl, a_fs, b_hs, b_vs, b_bl, b_fs;
    logic [7:0] a_fc, b_fc;

    vga_timing_gen u_a (
        .vclock_in(clk), .reset_n_in(rst_a), .pix_en_in(en_a),
        .hcount_out(a_h), .vcount_out(a_v), .hsync_out(a_hs),
        .vsync_out(a_vs), .blank_out(a_bl), .frame_start_out(a_fs),
        .frame_count_out(a_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
        .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
        .H_POL(1'b0), .V_POL(1'b0)
    ) u_b (
        .vclock_in(clk), .reset_n_in(rst_b), .pix_en_in(en_b),
        .hcount_out(b_h), .vcount_out(b_v), .hsync_out(b_hs),
        .vsync_out(b_vs), .blank_out(b_bl), .frame_start_out(b_fs),
        .frame_count_out(b_fc)
    );

    wire [34:0] a_vec = {a_h, a_v, a_hs, a_vs, a_bl, a_fs, a_fc};
    wire [34:0] b_vec = {b_h, b_v, b_hs, b_vs, b_bl, b_fs, b_fc};
    localparam logic [34:0] RST_VEC = {12'd0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};

    int total = 0;
    int passed = 0;
    int pa = 0, fca = 0, pb = 0, fcb = 0;
    bit fsa = 0, fsb = 0;

    // Model: frame position is a single linear pixel index.
    function automatic logic [34:0] ref_out(int p, int fc, bit fs,
            int ha, int hf, int hs, int hb, int va, int vf, int vs);
        int ht = ha + hf + hs + hb;
        int h = p % ht;
        int v = p / ht;
        bit hsy = !(h >= ha + hf && h < ha + hf + hs);
        bit vsy = !(v >= va + vf && v < va + vf + vs);
        bit bl = (h >= ha) || (v >= va);
        return {12'(h), 11'(v), hsy, vsy, bl, fs, 8'(fc)};
    endfunction

    task automatic chk(string nm, logic [34:0] act, logic [34:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic cyc(input logic ea, input logic eb);
        en_a = ea;
        en_b = eb;
        @(posedge clk);
        if (!rst_a) begin
            pa = 0; fca = 0; fsa = 0;
        end else begin
            fsa = 0;
            if (ea) begin
                pa++;
                if (pa == AHT * AVT) begin
                    pa = 0; fsa = 1; fca = (fca + 1) % 256;
                end
            end
        end
        if (!rst_b) begin
            pb = 0; fcb = 0; fsb = 0;
        end else begin
            fsb = 0;
            if (eb) begin
                pb++;
                if (pb == BHT * BVT) begin
                    pb = 0; fsb = 1; fcb = (fcb + 1) % 256;
                end
            end
        end
        #1;
        chk("a_cycle", a_vec, ref_out(pa, fca, fsa, AHA, AHF, AHS, AHB, AVA, AVF, AVS));
        chk("b_cycle", b_vec, ref_out(pb, fcb, fsb, BHA, BHF, BHS, BHB, BVA, BVF, BVS));
    endtask

    typedef struct {
        logic        en;
        logic [11:0] h;
        logic        hs;
        logic        bl;
    } gate_vec_t;

    gate_vec_t gtab[6];
    int lowcnt, pulses, en_cnt, guard;
    logic e;

    initial begin
        gtab[0] = '{1'b1, 12'd1046, 1'b1, 1'b1};
        gtab[1] = '{1'b0, 12'd1046, 1'b1, 1'b1};
        gtab[2] = '{1'b0, 12'd1046, 1'b1, 1'b1};
        gtab[3] = '{1'b1, 12'd1047, 1'b1, 1'b1};
        gtab[4] = '{1'b1, 12'd1048, 1'b0, 1'b1};
        gtab[5] = '{1'b1, 12'd1049, 1'b0, 1'b1};

        rst_a = 1'b0;
        rst_b = 1'b0;
        en_a = 1'b0;
        en_b = 1'b0;
        repeat (5) cyc(1'b1, 1'b0);
        chk("a_reset", a_vec, RST_VEC);
        chk("b_reset", b_vec, RST_VEC);

        rst_a = 1'b1;
        repeat (1023) cyc(1'b1, 1'b0);
        chk("a_h1023", 35'({a_h, a_bl}), 35'({12'd1023, 1'b0}));
        cyc(1'b1, 1'b0);
        chk("a_blank_rise", 35'({a_h, a_bl}), 35'({12'd1024, 1'b1}));
        repeat (21) cyc(1'b1, 1'b0);
        chk("a_h1045", 35'(a_h), 35'(12'd1045));

        foreach (gtab[i]) begin
            cyc(gtab[i].en, 1'b0);
            chk("a_gate", 35'({a_h, a_hs, a_bl}),
                35'({gtab[i].h, gtab[i].hs, gtab[i].bl}));
        end

        lowcnt = 2;
        guard = 0;
        while (a_h != 12'd1343 && guard < 400) begin
            cyc(1'b1, 1'b0);
            if (!a_hs) lowcnt++;
            guard++;
        end
        chk("a_hsync_width", 35'(lowcnt), 35'(136));
        cyc(1'b1, 1'b0);
        chk("a_line_wrap", 35'({a_h, a_v}), 35'({12'd0, 11'd1}));

        repeat (3000) cyc(1'($urandom_range(0, 3) != 0), 1'b0);
        en_a = 1'b0;

        rst_b = 1'b1;
        guard = 0;
        while (!(b_fc == 8'd3 && b_h == 12'd5 && b_v == 11'd3) && guard < 2000) begin
            cyc(1'b0, 1'($urandom_range(0, 3) != 0));
            guard++;
        end
        chk("b_in_syncs", 35'({b_h, b_v, b_hs, b_vs, b_fc}),
            35'({12'd5, 11'd3, 1'b0, 1'b0, 8'd3}));
        #3;
        rst_b = 1'b0;
        #1;
        chk("b_async_rst", b_vec, RST_VEC);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        rst_b = 1'b1;

        pulses = 0;
        en_cnt = 0;
        guard = 0;
        while (pulses < 257 && guard < 20000) begin
            e = 1'($urandom_range(0, 3) != 0);
            cyc(1'b0, e);
            if (e) en_cnt++;
            if (b_fs) begin
                pulses++;
                chk("b_period", 35'(en_cnt), 35'(35));
                chk("b_fc_step", 35'(b_fc), 35'(pulses % 256));
                if (pulses == 256) chk("b_fc_wrap", 35'(b_fc), 35'(0));
                en_cnt = 0;
            end
            guard++;
        end
        chk("b_pulses", 35'(pulses), 35'(257));

        guard = 0;
        while (!b_fs && guard < 100) begin
            cyc(1'b0, 1'b1);
            guard++;
        end
        chk("b_fs_seen", 35'({b_fs, b_h, b_v}), 35'({1'b1, 12'd0, 11'd0}));
        cyc(1'b0, 1'b0);
        chk("b_fs_one_cycle", 35'({b_fs, b_h, b_v}), 35'({1'b0, 12'd0, 11'd0}));
        cyc(1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
